fft_frame_packer: RTL
=====================

Name: fft_frame_packer

Overview:
Downstream of fft_data_selector. Takes the sparse, selected 16-bit sample stream (valid pulses, no backpressure) and packs it into fixed-length FFT frames on an AXI-Stream master, with o_tlast on the last sample of each frame. Frames are buffered in an internal FIFO so the FFT core may stall via i_tready. Only whole frames are ever admitted: a frame that cannot fit is dropped entirely and counted, so tlast alignment is never lost.

Parameters:
DATA_W, 16, sample width
FFT_LEN, 16, samples per frame; power of two, 4..4096
FIFO_DEPTH, 32, FIFO entries; power of two, must be >= FFT_LEN (elaboration error otherwise)
CNT_W, 16, width of dropped-frame counter

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_valid  in  1  input sample strobe from selector
i_data  in  DATA_W  input sample, qualified by i_valid
o_tdata  out  DATA_W  AXI-S data
o_tvalid  out  1  AXI-S valid
i_tready  in  1  AXI-S ready
o_tlast  out  1  high on final sample (index FFT_LEN-1) of each frame
o_frames_dropped  out  CNT_W  saturating count of whole frames discarded
o_overflow  out  1  sticky; set on first dropped frame, cleared only by reset

Behaviour:
- Reset (async assert, sync release): FIFO empty, o_tvalid=0, o_tdata=0, o_tlast=0, o_frames_dropped=0, o_overflow=0, input sample index=0, input FSM=ADMIT_CHECK.
- Input sample index: log2(FFT_LEN) bits, increments on every i_valid regardless of admit/drop, wraps FFT_LEN-1 -> 0. Index 0 after reset defines frame boundaries.
- Input FSM:
  - ADMIT_CHECK (index==0 expected): on i_valid, if (FIFO_DEPTH - count) >= FFT_LEN, write sample, go ACCEPT. Otherwise discard sample, increment o_frames_dropped (saturate at all-ones), set o_overflow, go DROP. count is the registered occupancy; a pop in the same cycle is not credited.
  - ACCEPT: every i_valid writes {index==FFT_LEN-1, i_data} into FIFO. On write of index FFT_LEN-1, go ADMIT_CHECK.
  - DROP: every i_valid discarded. On index FFT_LEN-1, go ADMIT_CHECK.
  - FFT_LEN==1 not supported.
- Write in ACCEPT can never hit full, guaranteed by admission check. FIFO full-write is an assertion failure.
- FIFO: DATA_W+1 wide (data + last flag), registered count, simultaneous push and pop leaves count unchanged.
- Output: first-word fall-through. o_tvalid = FIFO non-empty. o_tdata/o_tlast show head entry. Pop on o_tvalid & i_tready. A sample written at edge N is visible with o_tvalid=1 after edge N (1-cycle latency, empty FIFO).
- AXI rules: while o_tvalid=1 and i_tready=0, o_tdata/o_tlast stay stable. o_tvalid never drops without a handshake.
- When i_tready is held high, throughput is one sample per cycle, well above the input rate.
- Reset mid-frame: FIFO contents and partial frame discarded, index returns to 0, so the next frame starts clean.

Test Plan:
- Free-flowing: i_tready=1, i_valid once every 16 cycles, data 1..32 -> two frames out, o_tdata 1..32 in order, o_tlast high only on data 16 and 32, o_frames_dropped=0.
- Backpressure: i_tready=0 throughout, feed 48 samples (FIFO_DEPTH=32) -> frames 1-2 buffered (count=32), frame 3 (data 33..48) dropped, o_frames_dropped=1, o_overflow=1. Then raise i_tready -> exactly data 1..32 out, tlast on 16 and 32.
- Admission boundary: count=16 at start of frame -> admitted (32-16=16 >= 16). count=17 -> whole frame dropped. No partial frames appear on the output.
- Stall stability: toggle i_tready pseudo-randomly -> o_tdata/o_tlast stable while stalled, no sample lost or duplicated, tlast every 16th transfer.
- Counter saturation: CNT_W=2, force 5 drops -> o_frames_dropped reads 3 and stays at 3.
- Reset mid-frame: assert i_reset after 7 accepted samples -> all outputs 0 immediately. After release, next 16 samples form a complete frame with tlast on the 16th.

Source files
------------

// File: rtl/fft_frame_packer.sv
// Packs a sparse selected-sample stream into fixed-length FFT frames on an AXI-Stream master.
// Frames are admitted whole or dropped whole, so tlast alignment survives downstream stalls.
module fft_frame_packer #(
  parameter int DATA_W     = 16,
  parameter int FFT_LEN    = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tvalid,
  input  logic              i_tready,
  output logic              o_tlast,
  output logic [CNT_W-1:0]  o_frames_dropped,
  output logic              o_overflow
);

  localparam int IDX_W = $clog2(FFT_LEN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FFT_LEN - 1);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FRAME_C   = (PTR_W + 1)'(FFT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  if (FFT_LEN < 4 || FFT_LEN > 4096 || (FFT_LEN & (FFT_LEN - 1)) != 0) begin : g_len_chk
    $error("FFT_LEN must be a power of two in 4..4096");
  end
  if (FIFO_DEPTH < FFT_LEN || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("FIFO_DEPTH must be a power of two and >= FFT_LEN");
  end

  typedef enum logic [1:0] {ADMIT_CHECK, ACCEPT, DROP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [CNT_W-1:0]   dropped_q, dropped_d;
  logic               overflow_q, overflow_d;
  logic [DATA_W:0]    mem_q [FIFO_DEPTH];

  logic               push;
  logic               pop;
  logic               last_sample;
  logic               room;
  logic [DATA_W:0]    head;

  // Admission uses the registered occupancy only; a same-cycle pop does not make room.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dropped_d   = dropped_q;
    overflow_d  = overflow_q;
    push        = 1'b0;
    pop         = (count_q != '0) && i_tready;
    last_sample = (idx_q == LAST_IDX);
    room        = (DEPTH_C - count_q) >= FRAME_C;

    if (i_valid) begin
      idx_d = idx_q + IDX_W'(1);
      case (state_q)
        ADMIT_CHECK: begin
          if (room) begin
            push    = 1'b1;
            state_d = ACCEPT;
          end else begin
            if (dropped_q != CNT_MAX) dropped_d = dropped_q + CNT_W'(1);
            overflow_d = 1'b1;
            state_d    = DROP;
          end
        end
        ACCEPT: begin
          push = 1'b1;
          if (last_sample) state_d = ADMIT_CHECK;
        end
        DROP: begin
          if (last_sample) state_d = ADMIT_CHECK;
        end
        default: state_d = ADMIT_CHECK;
      endcase
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ADMIT_CHECK;
      idx_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {last_sample, i_data};
  end

  assign head             = mem_q[rd_ptr_q];
  assign o_tvalid         = (count_q != '0);
  assign o_tdata          = o_tvalid ? head[DATA_W-1:0] : '0;
  assign o_tlast          = o_tvalid & head[DATA_W];
  assign o_frames_dropped = dropped_q;
  assign o_overflow       = overflow_q;

  a_no_full_write: assert property (@(posedge i_clk) disable iff (i_reset)
    !(push && count_q == DEPTH_C));

endmodule
